// File: rtl/bru_pkg.sv
// Shared definitions for the branch unit: branch opcodes, the BHT counter type and its
// reset value, and the opcode/counter helper functions.
package bru_pkg;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BGT  = 6'h06;
    localparam logic [5:0] OP_BGTE = 6'h07;
    localparam logic [5:0] OP_BLE  = 6'h08;
    localparam logic [5:0] OP_BLEQ = 6'h09;
    localparam logic [5:0] OP_BLEU = 6'h0A;
    localparam logic [5:0] OP_BGTU = 6'h0B;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_INIT = WNT;

    // Branch opcodes occupy one contiguous range.
    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGTU);
    endfunction

    function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
        bht_state_t nxt;
        nxt = cur;
        if (taken && cur != ST)
            nxt = bht_state_t'(cur + 2'd1);
        else if (!taken && cur != SNT)
            nxt = bht_state_t'(cur - 2'd1);
        return nxt;
    endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: BHT_DEPTH 2-bit saturating counters with one asynchronous read
// port and one synchronous update port. A same-cycle read of the written entry sees the old value.
module bru_bht
    import bru_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    localparam int IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_state_t       rd_state,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_state_t cnt [BHT_DEPTH];

    assign rd_state = cnt[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                cnt[i] <= BHT_INIT;
        end else if (wr_en) begin
            cnt[wr_idx] <= bht_next(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: resolves conditional branches in EX, registers outcome/target/mispredict,
// and trains a 2-bit BHT. Optional perf counters: define BRANCH_PREDICT_UNIT_PERF_EN.
module branch_predict_unit
    import bru_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [5:0]      ex_opcode,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs_data,
    input  logic [XLEN-1:0] ex_rt_data,
    input  logic [15:0]     ex_imm16,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic [PC_W-1:0] res_target,
    output logic            res_mispredict,
    output logic [PC_W-1:0] res_redirect_pc
`ifdef BRANCH_PREDICT_UNIT_PERF_EN
   ,output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    logic            taken;
    logic            resolve;
    logic [PC_W-1:0] imm_ext;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] target;
    bht_state_t      rd_state;

    always_comb begin
        taken = 1'b0;
        unique case (ex_opcode)
            OP_BEQ:  taken = (ex_rs_data == ex_rt_data);
            OP_BNE:  taken = (ex_rs_data != ex_rt_data);
            OP_BGT:  taken = ($signed(ex_rs_data) >  $signed(ex_rt_data));
            OP_BGTE: taken = ($signed(ex_rs_data) >= $signed(ex_rt_data));
            OP_BLE:  taken = ($signed(ex_rs_data) <  $signed(ex_rt_data));
            OP_BLEQ: taken = ($signed(ex_rs_data) <= $signed(ex_rt_data));
            OP_BLEU: taken = (ex_rs_data < ex_rt_data);
            OP_BGTU: taken = (ex_rs_data > ex_rt_data);
            default: taken = 1'b0;
        endcase
    end

    // Flush wins over valid; non-branch opcodes never resolve.
    assign resolve = ex_valid & ~ex_flush & is_branch(ex_opcode);

    // Offset is in words; all PC arithmetic wraps silently.
    assign imm_ext = {{(PC_W-16){ex_imm16[15]}}, ex_imm16};
    assign seq_pc  = ex_pc + PC_W'(4);
    assign target  = seq_pc + (imm_ext << 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_target      <= '0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
        end else begin
            res_valid      <= resolve;
            res_mispredict <= resolve & (taken != ex_pred_taken);
            if (resolve) begin
                res_taken       <= taken;
                res_target      <= target;
                res_redirect_pc <= taken ? target : seq_pc;
            end
        end
    end

    bru_bht #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (f_pc[IDX_W+1:2]),
        .rd_state (rd_state),
        .wr_en    (resolve),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign f_pred_taken = rd_state[1];

`ifdef BRANCH_PREDICT_UNIT_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (resolve) begin
            perf_branches <= perf_branches + 32'd1;
            if (taken != ex_pred_taken)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule
